// File: rtl/axin_demux.sv
// Packet demultiplexer: routes each packet to a bitmask of output ports and
// broadcasts its beats in lock-step. Packets with an empty mask are dropped and counted.
module axin_demux #(
  parameter int NOUT         = 4,
  parameter int DW           = 64,
  parameter int WBITS        = $clog2(DW/8),
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DW-1:0]         S_DATA,
  input  logic [WBITS-1:0]      S_BYTES,
  input  logic                  S_LAST,
  input  logic                  S_ABORT,
  input  logic [NOUT-1:0]       i_dest,
  output logic [NOUT-1:0]       M_VALID,
  input  logic [NOUT-1:0]       M_READY,
  output logic [NOUT*DW-1:0]    M_DATA,
  output logic [NOUT*WBITS-1:0] M_BYTES,
  output logic [NOUT-1:0]       M_LAST,
  output logic [NOUT-1:0]       M_ABORT,
  output logic [15:0]           o_drops
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t          state_q, state_d;
  logic [NOUT-1:0] dest_q, dest_d;
  logic [NOUT-1:0] m_valid_q, m_valid_d;
  logic [NOUT-1:0] m_abort_q, m_abort_d;
  logic [15:0]     drops_q, drops_d;

  logic [NOUT-1:0] active_mask;
  logic [NOUT-1:0] port_free;
  logic [NOUT-1:0] load;
  logic            s_ready;
  logic            accept;
  logic            fwd;
  logic            drop_beat;
  logic            route_abort;

  // The first beat is steered by i_dest; the rest of the packet by the latched mask.
  assign active_mask = (state_q == ROUTE) ? dest_q : i_dest;
  assign port_free   = ~m_valid_q | M_READY;
  assign accept      = S_VALID && s_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (accept && !S_ABORT) begin
          if (i_dest != '0) begin
            dest_d = i_dest;
            if (!S_LAST) state_d = ROUTE;
          end else if (!S_LAST) begin
            state_d = DROP;
          end
        end
      end
      ROUTE:   if (S_ABORT || (accept && S_LAST)) state_d = IDLE;
      DROP:    if (S_ABORT || (S_VALID && S_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    fwd         = 1'b0;
    drop_beat   = 1'b0;
    route_abort = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready   = S_ABORT || (&(port_free | ~active_mask));
        fwd       = accept && !S_ABORT && (i_dest != '0);
        drop_beat = accept && !S_ABORT && (i_dest == '0);
      end
      ROUTE: begin
        // An abort is always swallowed, even if outputs are stalled.
        s_ready     = S_ABORT || (&(port_free | ~active_mask));
        fwd         = accept && !S_ABORT;
        route_abort = S_ABORT;
      end
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    drops_d = drops_q;
    if (drop_beat && (drops_q != 16'hFFFF)) drops_d = drops_q + 16'd1;
    load      = fwd ? active_mask : '0;
    m_abort_d = route_abort ? dest_q : '0;
    m_valid_d = (m_valid_q & ~M_READY & ~m_abort_d) | load;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dest_q    <= '0;
      m_valid_q <= '0;
      m_abort_q <= '0;
      drops_q   <= '0;
    end else begin
      dest_q    <= dest_d;
      m_valid_q <= m_valid_d;
      m_abort_q <= m_abort_d;
      drops_q   <= drops_d;
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_port
    logic [DW-1:0]    data_q, data_d;
    logic [WBITS-1:0] bytes_q, bytes_d;
    logic             last_q, last_d;

    always_comb begin
      data_d  = data_q;
      bytes_d = bytes_q;
      last_d  = last_q;
      if (load[gi]) begin
        data_d  = S_DATA;
        bytes_d = S_BYTES;
        last_d  = S_LAST;
      end else if (OPT_LOWPOWER && !m_valid_d[gi]) begin
        data_d  = '0;
        bytes_d = '0;
        last_d  = 1'b0;
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        data_q  <= '0;
        bytes_q <= '0;
        last_q  <= 1'b0;
      end else begin
        data_q  <= data_d;
        bytes_q <= bytes_d;
        last_q  <= last_d;
      end
    end

    assign M_DATA[gi*DW +: DW]        = data_q;
    assign M_BYTES[gi*WBITS +: WBITS] = bytes_q;
    assign M_LAST[gi]                 = last_q;
  end

  assign S_READY = s_ready;
  assign M_VALID = m_valid_q;
  assign M_ABORT = m_abort_q;
  assign o_drops = drops_q;

endmodule

// File: tb/tb_axin_demux.sv
// Self-checking bench for axin_demux: directed vector table, hand sequences for
// backpressure / saturation / reset, then random traffic against a packet-level model.
module tb_axin_demux;

  localparam int NOUT = 4;
  localparam int DW = 64;
  localparam int WB = 3;
  localparam int NV = 23;

  logic                 i_clk;
  logic                 i_reset;
  logic                 S_VALID;
  logic                 S_READY;
  logic [DW-1:0]        S_DATA;
  logic [WB-1:0]        S_BYTES;
  logic                 S_LAST;
  logic                 S_ABORT;
  logic [NOUT-1:0]      i_dest;
  logic [NOUT-1:0]      M_VALID;
  logic [NOUT-1:0]      M_READY;
  logic [NOUT*DW-1:0]   M_DATA;
  logic [NOUT*WB-1:0]   M_BYTES;
  logic [NOUT-1:0]      M_LAST;
  logic [NOUT-1:0]      M_ABORT;
  logic [15:0]          o_drops;

  axin_demux #(.NOUT(NOUT), .DW(DW), .WBITS(WB), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_BYTES(S_BYTES),
    .S_LAST(S_LAST), .S_ABORT(S_ABORT), .i_dest(i_dest),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_BYTES(M_BYTES),
    .M_LAST(M_LAST), .M_ABORT(M_ABORT), .o_drops(o_drops)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pdata(input int k);
    return M_DATA[k*DW +: DW];
  endfunction

  function automatic logic [2:0] pbytes(input int k);
    return M_BYTES[k*WB +: WB];
  endfunction

  task automatic drive(input logic v, input logic l, input logic a, input logic [3:0] d,
                       input logic [63:0] data, input logic [3:0] rdy);
    S_VALID = v; S_LAST = l; S_ABORT = a; i_dest = d;
    S_DATA = data; S_BYTES = data[2:0]; M_READY = rdy;
  endtask

  typedef struct {
    logic        v, l, a;
    logic [3:0]  d;
    logic [63:0] data;
    logic        exp_rdy;
    logic [3:0]  exp_mv;
    logic [3:0]  exp_ab;
    logic [63:0] exp_data;
    logic        exp_last;
    logic [15:0] exp_drops;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic l, input logic a, input logic [3:0] d,
                              input logic [63:0] data, input logic [3:0] mv, input logic [3:0] ab,
                              input logic [63:0] ed, input logic el, input logic [15:0] dr);
    vec_t r;
    r.v = v; r.l = l; r.a = a; r.d = d; r.data = data; r.exp_rdy = 1'b1;
    r.exp_mv = mv; r.exp_ab = ab; r.exp_data = ed; r.exp_last = el; r.exp_drops = dr;
    return r;
  endfunction

  vec_t        tbl [NV];
  logic [63:0] bp_data [4];
  logic [63:0] q0_d[$], q2_d[$];
  logic        q0_l[$], q2_l[$];
  int          sent, cyc;

  // Reference model: per-port one-deep output slot plus packet context.
  logic        m_route, m_drop;
  logic [3:0]  m_dest, m_sv, m_ab, nab, mask;
  logic [63:0] m_sd [4];
  logic [2:0]  m_sb [4];
  logic        m_sl [4];
  int          m_drops;
  logic        er, acc;
  logic [3:0]  r_rdy;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    drive(0, 0, 0, 4'h0, 64'h0, 4'hF);
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_mvalid", 64'(M_VALID), 64'h0);
    chk("rst_mabort", 64'(M_ABORT), 64'h0);
    chk("rst_drops", 64'(o_drops), 64'h0);
    chk("rst_sready", 64'(S_READY), 64'h1);
    @(posedge i_clk); #1;

    // ---------------- directed table ----------------
    tbl[0]  = mk(1,0,0,4'b0010,64'hD0,  4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[1]  = mk(1,0,0,4'b0000,64'hD1,  4'b0010,4'b0000,64'hD0, 0,16'd0);
    tbl[2]  = mk(1,1,0,4'b0000,64'hD2,  4'b0010,4'b0000,64'hD1, 0,16'd0);
    tbl[3]  = mk(0,0,0,4'b0000,64'h0,   4'b0010,4'b0000,64'hD2, 1,16'd0);
    tbl[4]  = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[5]  = mk(1,1,0,4'b0001,64'hE0,  4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[6]  = mk(1,1,0,4'b0010,64'hE1,  4'b0001,4'b0000,64'hE0, 1,16'd0);
    tbl[7]  = mk(0,0,0,4'b0000,64'h0,   4'b0010,4'b0000,64'hE1, 1,16'd0);
    tbl[8]  = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[9]  = mk(1,0,0,4'b1000,64'hF0,  4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[10] = mk(1,0,1,4'b0000,64'hF1,  4'b1000,4'b0000,64'hF0, 0,16'd0);
    tbl[11] = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b1000,64'h0,  0,16'd0);
    tbl[12] = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[13] = mk(1,1,0,4'b1000,64'h60,  4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[14] = mk(0,0,0,4'b0000,64'h0,   4'b1000,4'b0000,64'h60, 1,16'd0);
    tbl[15] = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[16] = mk(1,0,0,4'b0000,64'h70,  4'b0000,4'b0000,64'h0,  0,16'd0);
    tbl[17] = mk(1,0,0,4'b0011,64'h71,  4'b0000,4'b0000,64'h0,  0,16'd1);
    tbl[18] = mk(1,0,0,4'b0000,64'h72,  4'b0000,4'b0000,64'h0,  0,16'd1);
    tbl[19] = mk(1,1,0,4'b0000,64'h73,  4'b0000,4'b0000,64'h0,  0,16'd1);
    tbl[20] = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd1);
    tbl[21] = mk(1,0,1,4'b0000,64'h80,  4'b0000,4'b0000,64'h0,  0,16'd1);
    tbl[22] = mk(0,0,0,4'b0000,64'h0,   4'b0000,4'b0000,64'h0,  0,16'd1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].d, tbl[i].data, 4'hF);
      @(negedge i_clk);
      chk($sformatf("vec%0d_sready", i), 64'(S_READY), 64'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_mvalid", i), 64'(M_VALID), 64'(tbl[i].exp_mv));
      chk($sformatf("vec%0d_mabort", i), 64'(M_ABORT), 64'(tbl[i].exp_ab));
      chk($sformatf("vec%0d_drops", i), 64'(o_drops), 64'(tbl[i].exp_drops));
      for (int k = 0; k < NOUT; k++) begin
        if (tbl[i].exp_mv[k]) begin
          chk($sformatf("vec%0d_data%0d", i, k), pdata(k), tbl[i].exp_data);
          chk($sformatf("vec%0d_last%0d", i, k), 64'(M_LAST[k]), 64'(tbl[i].exp_last));
        end
      end
      @(posedge i_clk); #1;
    end

    // ---------------- broadcast with port-2 stall ----------------
    bp_data[0] = 64'hB000_0000_0000_0001;
    bp_data[1] = 64'hB000_0000_0000_0002;
    bp_data[2] = 64'hB000_0000_0000_0003;
    bp_data[3] = 64'hB000_0000_0000_0004;
    sent = 0; cyc = 0;
    while (sent < 4 && cyc < 40) begin
      drive(1, sent == 3, 0, 4'b0101, bp_data[sent], (cyc >= 1 && cyc <= 3) ? 4'b1011 : 4'b1111);
      @(negedge i_clk);
      chk($sformatf("bp_sready_c%0d", cyc), 64'(S_READY), (cyc >= 1 && cyc <= 3) ? 64'h0 : 64'h1);
      if (cyc >= 1 && cyc <= 3) begin
        chk($sformatf("bp_hold_valid_c%0d", cyc), 64'(M_VALID[2]), 64'h1);
        chk($sformatf("bp_hold_data_c%0d", cyc), pdata(2), bp_data[0]);
      end
      if (M_VALID[0] && M_READY[0]) begin q0_d.push_back(pdata(0)); q0_l.push_back(M_LAST[0]); end
      if (M_VALID[2] && M_READY[2]) begin q2_d.push_back(pdata(2)); q2_l.push_back(M_LAST[2]); end
      if (S_READY) sent++;
      cyc++;
      @(posedge i_clk); #1;
    end
    chk("bp_sent", 64'(sent), 64'd4);
    drive(0, 0, 0, 4'h0, 64'h0, 4'hF);
    repeat (4) begin
      @(negedge i_clk);
      if (M_VALID[0] && M_READY[0]) begin q0_d.push_back(pdata(0)); q0_l.push_back(M_LAST[0]); end
      if (M_VALID[2] && M_READY[2]) begin q2_d.push_back(pdata(2)); q2_l.push_back(M_LAST[2]); end
      chk("bp_port1_idle", 64'(M_VALID[1]), 64'h0);
      @(posedge i_clk); #1;
    end
    chk("bp_count_p0", 64'(q0_d.size()), 64'd4);
    chk("bp_count_p2", 64'(q2_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_p0_beat%0d", i), (i < q0_d.size()) ? q0_d[i] : 64'h0, bp_data[i]);
      chk($sformatf("bp_p2_beat%0d", i), (i < q2_d.size()) ? q2_d[i] : 64'h0, bp_data[i]);
      chk($sformatf("bp_p0_last%0d", i), (i < q0_l.size()) ? 64'(q0_l[i]) : 64'h2, 64'(i == 3));
      chk($sformatf("bp_p2_last%0d", i), (i < q2_l.size()) ? 64'(q2_l[i]) : 64'h2, 64'(i == 3));
    end

    // ---------------- drop counter saturation (one drop per clock) ----------------
    drive(1, 1, 0, 4'h0, 64'h0, 4'hF);
    repeat (65533) @(posedge i_clk);
    @(negedge i_clk);
    chk("drops_fffe", 64'(o_drops), 64'hFFFE);
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    chk("drops_sat", 64'(o_drops), 64'hFFFF);
    chk("drops_sready", 64'(S_READY), 64'h1);
    S_VALID = 1'b0;
    @(posedge i_clk); #1;

    // ---------------- reset mid-packet ----------------
    drive(1, 0, 0, 4'b0001, 64'hC0, 4'h0);
    @(posedge i_clk); #1;
    drive(1, 0, 0, 4'b0000, 64'hC1, 4'h0);
    @(negedge i_clk);
    chk("rstmid_mvalid_before", 64'(M_VALID), 64'h1);
    #2 i_reset = 1'b1;
    S_VALID = 1'b0;
    #1;
    chk("rstmid_mvalid_now", 64'(M_VALID), 64'h0);
    chk("rstmid_mabort_now", 64'(M_ABORT), 64'h0);
    chk("rstmid_drops_now", 64'(o_drops), 64'h0);
    @(negedge i_clk);
    chk("rstmid_mabort_held", 64'(M_ABORT), 64'h0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    drive(1, 0, 0, 4'b0001, 64'hCA, 4'hF);
    @(negedge i_clk);
    chk("rstpkt_sready", 64'(S_READY), 64'h1);
    chk("rstpkt_mabort", 64'(M_ABORT), 64'h0);
    @(posedge i_clk); #1;
    drive(1, 1, 0, 4'b0000, 64'hCB, 4'hF);
    @(negedge i_clk);
    chk("rstpkt_v0", 64'(M_VALID), 64'h1);
    chk("rstpkt_d0", pdata(0), 64'hCA);
    chk("rstpkt_l0", 64'(M_LAST[0]), 64'h0);
    @(posedge i_clk); #1;
    drive(0, 0, 0, 4'h0, 64'h0, 4'hF);
    @(negedge i_clk);
    chk("rstpkt_v1", 64'(M_VALID), 64'h1);
    chk("rstpkt_d1", pdata(0), 64'hCB);
    chk("rstpkt_l1", 64'(M_LAST[0]), 64'h1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rstpkt_done", 64'(M_VALID), 64'h0);
    @(posedge i_clk); #1;

    // ---------------- random traffic vs reference model ----------------
    m_route = 1'b0; m_drop = 1'b0; m_dest = '0; m_sv = '0; m_ab = '0; m_drops = 0;
    for (int k = 0; k < NOUT; k++) begin m_sd[k] = '0; m_sb[k] = '0; m_sl[k] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NOUT; k++) r_rdy[k] = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
            {$urandom, $urandom}, r_rdy);
      @(negedge i_clk);
      mask = m_route ? m_dest : i_dest;
      er = 1'b1;
      if (!m_drop && !S_ABORT)
        for (int k = 0; k < NOUT; k++)
          if (mask[k] && m_sv[k] && !M_READY[k]) er = 1'b0;
      chk($sformatf("rnd%0d_sready", c), 64'(S_READY), 64'(er));
      chk($sformatf("rnd%0d_mvalid", c), 64'(M_VALID), 64'(m_sv));
      chk($sformatf("rnd%0d_mabort", c), 64'(M_ABORT), 64'(m_ab));
      chk($sformatf("rnd%0d_drops", c), 64'(o_drops), 64'(m_drops));
      for (int k = 0; k < NOUT; k++) begin
        if (m_sv[k]) begin
          chk($sformatf("rnd%0d_data%0d", c, k), pdata(k), m_sd[k]);
          chk($sformatf("rnd%0d_bytes%0d", c, k), 64'(pbytes(k)), 64'(m_sb[k]));
          chk($sformatf("rnd%0d_last%0d", c, k), 64'(M_LAST[k]), 64'(m_sl[k]));
        end
      end
      acc = S_VALID && er;
      nab = '0;
      for (int k = 0; k < NOUT; k++) if (m_sv[k] && M_READY[k]) m_sv[k] = 1'b0;
      if (m_drop) begin
        if (S_ABORT || (S_VALID && S_LAST)) m_drop = 1'b0;
      end else if (m_route) begin
        if (S_ABORT) begin
          nab = m_dest;
          m_sv = m_sv & ~m_dest;
          m_route = 1'b0;
        end else if (acc) begin
          for (int k = 0; k < NOUT; k++)
            if (m_dest[k]) begin m_sv[k] = 1'b1; m_sd[k] = S_DATA; m_sb[k] = S_BYTES; m_sl[k] = S_LAST; end
          if (S_LAST) m_route = 1'b0;
        end
      end else if (acc && !S_ABORT) begin
        if (i_dest != 4'h0) begin
          m_dest = i_dest;
          for (int k = 0; k < NOUT; k++)
            if (i_dest[k]) begin m_sv[k] = 1'b1; m_sd[k] = S_DATA; m_sb[k] = S_BYTES; m_sl[k] = S_LAST; end
          m_route = !S_LAST;
        end else begin
          if (m_drops < 65535) m_drops++;
          m_drop = !S_LAST;
        end
      end
      m_ab = nab;
      @(posedge i_clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axin_demux.md
AXIN_DEMUX -- requirements
Module: axin_demux

Interface
REQ-001 SHALL have parameter NOUT, default 4, number of outgoing packet ports.
REQ-002 SHALL have parameter DW, default 64, data bits per beat.
REQ-003 SHALL have parameter WBITS, default $clog2(DW/8), width of the byte-count field.
REQ-004 SHALL have parameter OPT_LOWPOWER, default 0, which zeroes M_DATA/M_BYTES/M_LAST whenever the matching M_VALID is low.
REQ-005 SHALL have ports:
- i_clk  in  1  clock; one clock domain.
- i_reset  in  1  reset; asynchronous, active-high.
- S_VALID  in  1  incoming beat valid.
- S_READY  out  1  incoming beat accepted.
- S_DATA  in  DW  incoming data.
- S_BYTES  in  WBITS  valid bytes on the last beat; 0 means all DW/8 bytes.
- S_LAST  in  1  final beat of the packet.
- S_ABORT  in  1  drop the packet in progress.
- i_dest  in  NOUT  destination bitmask, sampled on the first beat of each packet.
- M_VALID  out  NOUT  per-port beat valid.
- M_READY  in  NOUT  per-port ready.
- M_DATA  out  NOUT*DW  per-port data.
- M_BYTES  out  NOUT*WBITS  per-port byte count.
- M_LAST  out  NOUT  per-port last.
- M_ABORT  out  NOUT  per-port abort.
- o_drops  out  16  count of packets dropped because the mask was empty, saturating.

Function
REQ-006 SHALL implement states IDLE, ROUTE and DROP; the state register resets to IDLE.
REQ-007 In IDLE, when S_VALID && !S_ABORT and i_dest!=0, SHALL latch dest=i_dest and forward the beat.
- If that beat is also S_LAST, SHALL stay in IDLE.
- Otherwise SHALL go to ROUTE.
REQ-008 In IDLE, when S_VALID && !S_ABORT and i_dest==0, SHALL consume the beat with S_READY=1 and increment o_drops.
- If that beat is not S_LAST, SHALL go to DROP.
REQ-009 In DROP, SHALL hold S_READY=1 and discard all beats.
- SHALL return to IDLE on an accepted S_LAST, or on S_ABORT.
REQ-010 In ROUTE, SHALL use the latched dest; i_dest is ignored until the next packet starts.
REQ-011 SHALL set S_READY = AND, over every k set in the active mask, of (!M_VALID[k] || M_READY[k]).
- The active mask is i_dest in IDLE and dest in ROUTE.
- S_READY is combinational and asserted only in IDLE/ROUTE per this rule.
REQ-012 An accepted beat SHALL appear on every selected port one clock later, with M_VALID=1 and identical DATA/BYTES/LAST (broadcast in lock-step).
REQ-013 Non-selected ports SHALL NOT change M_VALID, which stays 0 for them.
REQ-014 M_VALID[k] SHALL clear after M_READY[k] when no new beat is accepted for port k in the same cycle.
REQ-015 While M_VALID[k] && !M_READY[k], M_DATA/M_BYTES/M_LAST[k] SHALL hold stable.
REQ-016 S_ABORT handling:
- S_ABORT in ROUTE SHALL set S_READY=1 regardless of output ready.
- SHALL set M_ABORT[k]=1 for one clock on every k in dest, with M_VALID[k]=0 in that same clock.
- SHALL return to IDLE.
REQ-017 S_ABORT in IDLE SHALL be consumed with no output activity.
REQ-018 S_ABORT and S_VALID in the same ROUTE cycle SHALL be treated as abort; the beat is discarded.
REQ-019 M_ABORT SHALL be issued independent of M_READY.
- It SHALL NOT be raised for a packet whose S_LAST was already accepted.
REQ-020 o_drops SHALL saturate at 16'hFFFF and never wrap.
REQ-021 A new packet's first beat SHALL be acceptable in the cycle after S_LAST is accepted, giving full throughput of one beat per clock.

Reset
REQ-022 Asserting i_reset SHALL immediately clear, without waiting for a clock edge:
- state to IDLE, dest to 0, M_VALID to 0, M_ABORT to 0, o_drops to 0.
- M_DATA/M_BYTES/M_LAST to 0 when OPT_LOWPOWER=1; otherwise they are don't-care.
REQ-023 Reset asserted mid-packet SHALL discard the packet without M_ABORT.
- After release, the first accepted S_VALID SHALL be treated as a new packet's first beat.

Verification
REQ-024 Unicast: i_dest=4'b0010, 3-beat packet D0,D1,D2 with S_LAST on D2, all M_READY=1 -> port 1 shows D0..D2 on cycles 1..3 with M_LAST on D2; ports 0,2,3 keep M_VALID=0.
REQ-025 Broadcast backpressure: i_dest=4'b0101, M_READY[2]=0 for 3 cycles -> S_READY=0 during the stall; ports 0 and 2 show the same beat order and data; no beat is duplicated or lost.
REQ-026 Mid-packet abort: dest=4'b1000, S_ABORT on beat 2 of 5 -> M_ABORT[3]=1 for exactly one clock; state returns to IDLE; the next packet routes normally.
REQ-027 Empty mask: i_dest=0, 4-beat packet -> S_READY=1 on all 4 beats, no M_VALID, o_drops=1; 65536 such packets -> o_drops=16'hFFFF.
REQ-028 Reset: assert i_reset mid-packet with M_VALID[0]=1 -> M_VALID=0 immediately, with no M_ABORT; after release, a packet with i_dest=4'b0001 is delivered intact.
REQ-029 Back-to-back: two single-beat packets on consecutive clocks to 4'b0001 then 4'b0010 -> each port receives exactly one beat with M_LAST=1, one clock apart.
